// File: rtl/pipectl_pkg.sv
// Shared definitions for the pipeline controller.
//   FWD_*          forward-select encodings driven on fwd_a / fwd_b
//   FORWARDUSE/SRC bit positions inside a forward select
//   XZR            zero-register index; never a hazard or forward source
//   step_e         what the pipe registers do on the next clock edge
package pipectl_pkg;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_EX1  = 2'b11;
   localparam logic [1:0] FWD_EX2  = 2'b10;

   localparam int FORWARDUSE = 1;
   localparam int FORWARDSRC = 0;

   localparam int unsigned XZR = 31;

   typedef enum logic [1:0] {
      STEP_ADV      = 2'd0,
      STEP_STALL    = 2'd1,
      STEP_REDIRECT = 2'd2
   } step_e;

endpackage

// File: rtl/pipeline_control_if.sv
// Datapath <-> pipeline controller signal bundle.
//   master : datapath side (drives decode/hazard info, receives controls)
//   slave  : controller side
// Parameters NSTAGES / REGADDRSIZE must match the controller instance.
interface pipeline_control_if #(
   parameter int NSTAGES     = 5,
   parameter int REGADDRSIZE = 5
);
   logic [REGADDRSIZE-1:0] id_ra;
   logic [REGADDRSIZE-1:0] id_rb;
   logic                   id_usea;
   logic                   id_useb;
   logic                   ex_memread;
   logic [REGADDRSIZE-1:0] ex_ra;
   logic [REGADDRSIZE-1:0] ex_rb;
   logic [REGADDRSIZE-1:0] ex_rd;
   logic                   m1_regwrite;
   logic [REGADDRSIZE-1:0] m1_rd;
   logic                   m2_regwrite;
   logic [REGADDRSIZE-1:0] m2_rd;
   logic                   br_taken;

   logic [NSTAGES-1:0]     stage_valid;
   logic [NSTAGES-1:0]     stage_en;
   logic                   pc_en;
   logic                   pc_load;
   logic                   stall;
   logic [1:0]             fwd_a;
   logic [1:0]             fwd_b;
   logic                   retire;

   modport master (
      output id_ra, id_rb, id_usea, id_useb, ex_memread, ex_ra, ex_rb, ex_rd,
             m1_regwrite, m1_rd, m2_regwrite, m2_rd, br_taken,
      input  stage_valid, stage_en, pc_en, pc_load, stall, fwd_a, fwd_b, retire
   );

   modport slave (
      input  id_ra, id_rb, id_usea, id_useb, ex_memread, ex_ra, ex_rb, ex_rd,
             m1_regwrite, m1_rd, m2_regwrite, m2_rd, br_taken,
      output stage_valid, stage_en, pc_en, pc_load, stall, fwd_a, fwd_b, retire
   );
endinterface

// File: rtl/pipectl_fwdsel.sv
// Single-operand forward comparator.
//   src            source register read in EX
//   m1_en, m1_rd   stage EX+1 is valid and writing m1_rd
//   m2_en, m2_rd   stage EX+2 is valid and writing m2_rd
//   fwd            FWD_EX1 / FWD_EX2 / FWD_NONE; nearer stage wins
module pipectl_fwdsel
   import pipectl_pkg::*;
#(
   parameter int REGADDRSIZE = 5
) (
   input  logic [REGADDRSIZE-1:0] src,
   input  logic                   m1_en,
   input  logic [REGADDRSIZE-1:0] m1_rd,
   input  logic                   m2_en,
   input  logic [REGADDRSIZE-1:0] m2_rd,
   output logic [1:0]             fwd
);

   localparam logic [REGADDRSIZE-1:0] ZR = REGADDRSIZE'(XZR);

   always_comb begin
      fwd = FWD_NONE;
      if (m1_en && (m1_rd == src) && (m1_rd != ZR)) begin
         fwd = FWD_EX1;
      end else if (m2_en && (m2_rd == src) && (m2_rd != ZR)) begin
         fwd = FWD_EX2;
      end
   end

endmodule

// File: rtl/pipeline_control.sv
// Valid/stall/flush/forward controller for an NSTAGES-deep LEGv8 pipeline.
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   bus (slave)   hazard/forward inputs from the datapath; stage_valid,
//                 stage_en, pc_en, pc_load, stall, fwd_a, fwd_b, retire out
//   perf_*        saturating event counters (only with PIPECTL_PERF_EN)
// Build option: define PIPECTL_PERF_EN to add perf_retired, perf_stalls and
// perf_flushed.
//
// step          | meaning
// STEP_ADV      | every stage shifts, IF fetches a new instruction
// STEP_STALL    | IF..ID hold, bubble enters EX, later stages shift
// STEP_REDIRECT | stages 1..BR_STAGE killed, older shift, IF fetches target
module pipeline_control
   import pipectl_pkg::*;
#(
   parameter int NSTAGES     = 5,
   parameter int ID_STAGE    = 1,
   parameter int EX_STAGE    = 2,
   parameter int BR_STAGE    = 4,
   parameter int REGADDRSIZE = 5,
   parameter int CNTSIZE     = 32
) (
   input  logic               clk,
   input  logic               rst,
   pipeline_control_if.slave  bus
`ifdef PIPECTL_PERF_EN
   ,
   output logic [CNTSIZE-1:0] perf_retired,
   output logic [CNTSIZE-1:0] perf_stalls,
   output logic [CNTSIZE-1:0] perf_flushed
`endif
);

   generate
      if ((NSTAGES < EX_STAGE + 3) || (BR_STAGE < EX_STAGE) || (BR_STAGE > NSTAGES - 1)) begin : g_bad_cfg
         $error("pipeline_control: illegal NSTAGES/EX_STAGE/BR_STAGE combination");
      end
   endgenerate

   localparam logic [REGADDRSIZE-1:0] ZR = REGADDRSIZE'(XZR);

   logic [NSTAGES-1:0] valid_q;
   logic [NSTAGES-1:0] valid_d;
   logic [NSTAGES-1:0] en;
   logic               hazard;
   logic               redirect;
   step_e              step;

   always_comb begin
      hazard = valid_q[ID_STAGE] && valid_q[EX_STAGE] && bus.ex_memread &&
               (bus.ex_rd != ZR) &&
               ((bus.id_usea && (bus.id_ra == bus.ex_rd)) ||
                (bus.id_useb && (bus.id_rb == bus.ex_rd)));
      redirect = bus.br_taken && valid_q[BR_STAGE];
   end

   // Redirect has priority: the stalled instruction is on the wrong path anyway.
   always_comb begin
      step = STEP_ADV;
      if (redirect) begin
         step = STEP_REDIRECT;
      end else if (hazard) begin
         step = STEP_STALL;
      end
   end

   always_comb begin
      valid_d = {valid_q[NSTAGES-2:0], 1'b1};
      en      = '1;
      case (step)
         STEP_STALL: begin
            for (int s = 0; s < NSTAGES; s++) begin
               if (s <= ID_STAGE) begin
                  valid_d[s] = valid_q[s];
                  en[s]      = 1'b0;
               end else if (s <= EX_STAGE) begin
                  valid_d[s] = 1'b0;
               end
            end
         end
         STEP_REDIRECT: begin
            for (int s = 1; s < NSTAGES; s++) begin
               if (s <= BR_STAGE) begin
                  valid_d[s] = 1'b0;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= NSTAGES'(1);
      end else begin
         valid_q <= valid_d;
      end
   end

   assign bus.stage_valid = valid_q;
   assign bus.stage_en    = en;
   assign bus.pc_en       = (step != STEP_STALL);
   assign bus.pc_load     = (step == STEP_REDIRECT);
   assign bus.stall       = (step == STEP_STALL);
   assign bus.retire      = valid_q[NSTAGES-1];

   logic m1_en;
   logic m2_en;

   assign m1_en = valid_q[EX_STAGE+1] && bus.m1_regwrite;
   assign m2_en = valid_q[EX_STAGE+2] && bus.m2_regwrite;

   pipectl_fwdsel #(.REGADDRSIZE(REGADDRSIZE)) u_fwd_a (
      .src   (bus.ex_ra),
      .m1_en (m1_en),
      .m1_rd (bus.m1_rd),
      .m2_en (m2_en),
      .m2_rd (bus.m2_rd),
      .fwd   (bus.fwd_a)
   );

   pipectl_fwdsel #(.REGADDRSIZE(REGADDRSIZE)) u_fwd_b (
      .src   (bus.ex_rb),
      .m1_en (m1_en),
      .m1_rd (bus.m1_rd),
      .m2_en (m2_en),
      .m2_rd (bus.m2_rd),
      .fwd   (bus.fwd_b)
   );

`ifdef PIPECTL_PERF_EN
   logic [CNTSIZE-1:0] killed;

   always_comb begin
      killed = '0;
      if (step == STEP_REDIRECT) begin
         for (int s = 1; s < NSTAGES; s++) begin
            if (s <= BR_STAGE) begin
               killed = killed + CNTSIZE'(valid_q[s]);
            end
         end
      end
   end

   function automatic logic [CNTSIZE-1:0] sat_add(input logic [CNTSIZE-1:0] a,
                                                  input logic [CNTSIZE-1:0] b);
      logic [CNTSIZE:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[CNTSIZE] ? '1 : sum[CNTSIZE-1:0];
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_retired <= '0;
         perf_stalls  <= '0;
         perf_flushed <= '0;
      end else begin
         perf_retired <= sat_add(perf_retired, CNTSIZE'(valid_q[NSTAGES-1]));
         perf_stalls  <= sat_add(perf_stalls, CNTSIZE'(step == STEP_STALL));
         perf_flushed <= sat_add(perf_flushed, killed);
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Bench for pipeline_control: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an instruction-slot
// model (each stage holds an instruction id, or -1 for a bubble).
module tb_pipeline_control;

   localparam int N  = 5;
   localparam int ID = 1;
   localparam int EX = 2;
   localparam int BR = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipeline_control_if #(.NSTAGES(N), .REGADDRSIZE(5)) bus ();

`ifdef PIPECTL_PERF_EN
   logic [31:0] perf_retired;
   logic [31:0] perf_stalls;
   logic [31:0] perf_flushed;
`endif

   pipeline_control #(
      .NSTAGES(N), .ID_STAGE(ID), .EX_STAGE(EX), .BR_STAGE(BR),
      .REGADDRSIZE(5), .CNTSIZE(32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef PIPECTL_PERF_EN
      ,
      .perf_retired (perf_retired),
      .perf_stalls  (perf_stalls),
      .perf_flushed (perf_flushed)
`endif
   );

   int pass_cnt  = 0;
   int total_cnt = 0;
   bit cmp_on    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- instruction-slot model ----------------
   int slot[N];
   int next_id   = 0;
   int m_retired = 0;
   int m_stalls  = 0;
   int m_flushed = 0;

   function automatic bit mv(input int s);
      return slot[s] >= 0;
   endfunction

   function automatic bit exp_redirect();
      return bus.br_taken && mv(BR);
   endfunction

   function automatic bit exp_stall();
      bit dep;
      dep = (bus.id_usea && bus.id_ra == bus.ex_rd) || (bus.id_useb && bus.id_rb == bus.ex_rd);
      return mv(ID) && mv(EX) && bus.ex_memread && bus.ex_rd != 5'd31 && dep && !exp_redirect();
   endfunction

   function automatic logic [1:0] exp_fwd(input logic [4:0] r);
      if (mv(EX + 1) && bus.m1_regwrite && bus.m1_rd == r && r != 5'd31) return 2'b11;
      if (mv(EX + 2) && bus.m2_regwrite && bus.m2_rd == r && r != 5'd31) return 2'b10;
      return 2'b00;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         slot[0] = next_id++;
         for (int s = 1; s < N; s++) slot[s] = -1;
         m_retired = 0;
         m_stalls  = 0;
         m_flushed = 0;
      end else begin
         if (mv(N - 1)) m_retired++;
         if (exp_redirect()) begin
            for (int s = 1; s <= BR; s++) if (mv(s)) m_flushed++;
            for (int s = N - 1; s > BR; s--) slot[s] = slot[s-1];
            for (int s = 1; s <= BR; s++) slot[s] = -1;
            slot[0] = next_id++;
         end else if (exp_stall()) begin
            m_stalls++;
            for (int s = N - 1; s > EX; s--) slot[s] = slot[s-1];
            slot[EX] = -1;
         end else begin
            for (int s = N - 1; s > 0; s--) slot[s] = slot[s-1];
            slot[0] = next_id++;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (cmp_on) begin
         logic [N-1:0] ev;
         logic [N-1:0] een;
         bit           er;
         bit           es;
         for (int s = 0; s < N; s++) ev[s] = mv(s);
         er  = exp_redirect();
         es  = exp_stall();
         een = '1;
         if (es) for (int s = 0; s <= ID; s++) een[s] = 1'b0;
         check("stage_valid", 32'(bus.stage_valid), 32'(ev));
         check("retire",      32'(bus.retire),      32'(ev[N-1]));
         check("stall",       32'(bus.stall),       32'(es));
         check("pc_load",     32'(bus.pc_load),     32'(er));
         check("pc_en",       32'(bus.pc_en),       32'(!es));
         check("stage_en",    32'(bus.stage_en),    32'(een));
         check("fwd_a",       32'(bus.fwd_a),       32'(exp_fwd(bus.ex_ra)));
         check("fwd_b",       32'(bus.fwd_b),       32'(exp_fwd(bus.ex_rb)));
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_idle();
      bus.id_ra = 5'd0; bus.id_rb = 5'd0; bus.id_usea = 1'b0; bus.id_useb = 1'b0;
      bus.ex_memread = 1'b0; bus.ex_ra = 5'd0; bus.ex_rb = 5'd0; bus.ex_rd = 5'd0;
      bus.m1_regwrite = 1'b0; bus.m1_rd = 5'd0; bus.m2_regwrite = 1'b0; bus.m2_rd = 5'd0;
      bus.br_taken = 1'b0;
   endtask

   function automatic logic [4:0] pick_reg();
      return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
   endfunction

   task automatic randomize_inputs();
      bus.id_ra       = pick_reg();
      bus.id_rb       = pick_reg();
      bus.id_usea     = ($urandom_range(0, 99) < 70);
      bus.id_useb     = ($urandom_range(0, 99) < 50);
      bus.ex_memread  = ($urandom_range(0, 99) < 40);
      bus.ex_ra       = pick_reg();
      bus.ex_rb       = pick_reg();
      bus.ex_rd       = pick_reg();
      bus.m1_regwrite = ($urandom_range(0, 99) < 60);
      bus.m1_rd       = pick_reg();
      bus.m2_regwrite = ($urandom_range(0, 99) < 60);
      bus.m2_rd       = pick_reg();
      bus.br_taken    = ($urandom_range(0, 99) < 15);
   endtask

   logic [N-1:0] fill[4];

   initial begin
      fill[0] = 5'b00011; fill[1] = 5'b00111; fill[2] = 5'b01111; fill[3] = 5'b11111;
      set_idle();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      cmp_on = 1'b1;

      // reset state and warm-up
      check("rst_valid",   32'(bus.stage_valid), 32'h01);
      check("rst_stall",   32'(bus.stall),       32'h0);
      check("rst_pc_load", 32'(bus.pc_load),     32'h0);
      check("rst_fwd_a",   32'(bus.fwd_a),       32'h0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #2;
         check("warmup_valid",  32'(bus.stage_valid), 32'(fill[i]));
         check("warmup_retire", 32'(bus.retire),      32'(i == 3));
      end

      // load-use stall
      bus.ex_memread = 1'b1; bus.ex_rd = 5'd3; bus.id_ra = 5'd3; bus.id_usea = 1'b1;
      #2;
      check("lu_stall",    32'(bus.stall),    32'h1);
      check("lu_pc_en",    32'(bus.pc_en),    32'h0);
      check("lu_stage_en", 32'(bus.stage_en), 32'h1c);
      @(posedge clk); #2;
      check("lu_valid_after", 32'(bus.stage_valid), 32'h1b);
      check("lu_one_cycle",   32'(bus.stall),       32'h0);

      // forwarding priority (stages 3 and 4 valid)
      set_idle();
      bus.m1_rd = 5'd5; bus.m2_rd = 5'd5; bus.m1_regwrite = 1'b1; bus.m2_regwrite = 1'b1;
      bus.ex_ra = 5'd5; bus.ex_rb = 5'd5;
      #1;
      check("fwd_a_ex1", 32'(bus.fwd_a), 32'h3);
      check("fwd_b_ex1", 32'(bus.fwd_b), 32'h3);
      bus.m1_regwrite = 1'b0;
      #1;
      check("fwd_a_ex2", 32'(bus.fwd_a), 32'h2);
      bus.m1_regwrite = 1'b1; bus.m1_rd = 5'd31; bus.m2_rd = 5'd31; bus.ex_ra = 5'd31;
      @(negedge clk); #1;
      check("fwd_a_xzr", 32'(bus.fwd_a), 32'h0);

      // taken branch on a full pipe
      @(posedge clk); #2;
      set_idle();
      repeat (4) @(posedge clk);
      #2;
      check("br_full", 32'(bus.stage_valid), 32'h1f);
      bus.br_taken = 1'b1;
      #1;
      check("br_pc_load", 32'(bus.pc_load), 32'h1);
      check("br_pc_en",   32'(bus.pc_en),   32'h1);
      check("br_stall",   32'(bus.stall),   32'h0);
      @(posedge clk); #2;
      check("br_valid_after", 32'(bus.stage_valid), 32'h01);
      set_idle();

      // redirect beats a simultaneous stall; asynchronous reset
      repeat (5) @(posedge clk);
      #2;
      bus.ex_memread = 1'b1; bus.ex_rd = 5'd7; bus.id_rb = 5'd7; bus.id_useb = 1'b1;
      bus.br_taken = 1'b1;
      #1;
      check("race_pc_load",  32'(bus.pc_load),  32'h1);
      check("race_stall",    32'(bus.stall),    32'h0);
      check("race_stage_en", 32'(bus.stage_en), 32'h1f);
      @(posedge clk); #2;
      check("race_valid_after", 32'(bus.stage_valid), 32'h01);
      set_idle();
      repeat (2) @(posedge clk);
      #2;
      check("pre_rst_valid", 32'(bus.stage_valid), 32'h07);
      rst = 1'b1;
      #1;
      check("async_rst_valid", 32'(bus.stage_valid), 32'h01);
      @(posedge clk); #2 rst = 1'b0;

      // randomized traffic, with occasional reset pulses
      repeat (600) begin
         @(posedge clk); #1;
         randomize_inputs();
         rst = ($urandom_range(0, 99) == 0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      set_idle();
      @(posedge clk); #2;
      cmp_on = 1'b0;

`ifdef PIPECTL_PERF_EN
      check("perf_retired", perf_retired, 32'(m_retired));
      check("perf_stalls",  perf_stalls,  32'(m_stalls));
      check("perf_flushed", perf_flushed, 32'(m_flushed));
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
